alu_issue_stage: RTL and testbench

- ID/EX boundary stage that produces everything the 32-bit ALU consumes: a 3-bit ALU control code, shift amount, and both operands.
- Decodes ALUOp/Funct into the ALU control code, applies operand forwarding and the immediate select, and registers the result.
- Uses a valid/ready handshake with stall and flush, so the ALU input is always a registered, glitch-free interface.

---
 rtl/alu_issue_stage_pkg.sv | 29 ++
 rtl/alu_issue_stage_ctl_decode.sv | 36 +++
 rtl/alu_issue_stage.sv | 119 +++++++++++
 tb/tb_alu_issue_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU control codes, ALUOp/Funct encodings and forwarding selects
// used by the issue stage and the control decoder.
package alu_issue_stage_pkg;

    localparam logic [2:0] CTL_AND = 3'b000;
    localparam logic [2:0] CTL_OR  = 3'b001;
    localparam logic [2:0] CTL_ADD = 3'b010;
    localparam logic [2:0] CTL_SLT = 3'b011;
    localparam logic [2:0] CTL_SUB = 3'b110;
    localparam logic [2:0] CTL_SRL = 3'b111;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ORI   = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;

    localparam logic [1:0] FWD_REG     = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;
    localparam logic [1:0] FWD_REG_ALT = 2'b11;

endpackage

// File: rtl/alu_issue_stage_ctl_decode.sv
// Combinational ALUOp/Funct to ALU control decode; flags unsupported R-type
// functions while falling back to add so the ALU still sees a defined code.
module alu_ctl_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic [2:0] o_ctl,
    output logic       o_illegal
);

    always_comb begin
        o_ctl     = CTL_ADD;
        o_illegal = 1'b0;
        case (i_alu_op)
            ALUOP_MEM: o_ctl = CTL_ADD;
            ALUOP_BR:  o_ctl = CTL_SUB;
            ALUOP_ORI: o_ctl = CTL_OR;
            default: begin
                case (i_funct)
                    FUNCT_ADD: o_ctl = CTL_ADD;
                    FUNCT_SUB: o_ctl = CTL_SUB;
                    FUNCT_AND: o_ctl = CTL_AND;
                    FUNCT_OR:  o_ctl = CTL_OR;
                    FUNCT_SLT: o_ctl = CTL_SLT;
                    FUNCT_SRL: o_ctl = CTL_SRL;
                    default: begin
                        o_ctl     = CTL_ADD;
                        o_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes ALU control, forwards operands, applies the
// immediate select and presents a registered valid/ready interface to the ALU.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic [4:0]       ShamtIn,
    input  logic [WIDTH-1:0] RsData,
    input  logic [WIDTH-1:0] RtData,
    input  logic [WIDTH-1:0] Imm,
    input  logic             ALUSrc,
    input  logic [1:0]       ForwardA,
    input  logic [1:0]       ForwardB,
    input  logic [WIDTH-1:0] MemResult,
    input  logic [WIDTH-1:0] WbResult,
    input  logic             Flush,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [2:0]       Ctl,
    output logic [4:0]       Shamt,
    output logic [WIDTH-1:0] DataA,
    output logic [WIDTH-1:0] DataB,
    output logic             Illegal,
    output logic [CNT_W-1:0] IssueCount
);

    logic             r_valid;
    logic [2:0]       r_ctl;
    logic [4:0]       r_shamt;
    logic [WIDTH-1:0] r_data_a;
    logic [WIDTH-1:0] r_data_b;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;

    logic [2:0]       w_ctl;
    logic             w_illegal;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_fwd_b;
    logic [WIDTH-1:0] w_op_b;
    logic             w_load;
    logic             w_xfer;

    alu_ctl_decode u_ctl_decode (
        .i_alu_op  (ALUOp),
        .i_funct   (Funct),
        .o_ctl     (w_ctl),
        .o_illegal (w_illegal)
    );

    always_comb begin
        w_op_a = RsData;
        case (ForwardA)
            FWD_MEM: w_op_a = MemResult;
            FWD_WB:  w_op_a = WbResult;
            default: w_op_a = RsData;
        endcase
    end

    // Forwarding resolves first so a forwarded rt never overrides an immediate.
    always_comb begin
        w_fwd_b = RtData;
        case (ForwardB)
            FWD_MEM: w_fwd_b = MemResult;
            FWD_WB:  w_fwd_b = WbResult;
            default: w_fwd_b = RtData;
        endcase
    end

    assign w_op_b  = ALUSrc ? Imm : w_fwd_b;
    assign InReady = !r_valid | OutReady;
    assign w_load  = InValid & InReady & !Flush;
    assign w_xfer  = r_valid & OutReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_ctl     <= 3'b000;
            r_shamt   <= '0;
            r_data_a  <= '0;
            r_data_b  <= '0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_xfer)
                r_count <= r_count + 1'b1;

            // Flush wins over both load and hold; data regs keep their last value.
            if (Flush) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_valid   <= 1'b1;
                r_ctl     <= w_ctl;
                r_shamt   <= ShamtIn;
                r_data_a  <= w_op_a;
                r_data_b  <= w_op_b;
                r_illegal <= w_illegal;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign OutValid   = r_valid;
    assign Ctl        = r_ctl;
    assign Shamt      = r_shamt;
    assign DataA      = r_data_a;
    assign DataB      = r_data_b;
    assign Illegal    = r_illegal;
    assign IssueCount = r_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode sweep, forwarding, stall, flush,
// reset during hold and issue-counter wrap with a 4-bit counter.
module tb_alu_issue_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             InValid;
    logic             InReady;
    logic [1:0]       ALUOp;
    logic [5:0]       Funct;
    logic [4:0]       ShamtIn;
    logic [WIDTH-1:0] RsData;
    logic [WIDTH-1:0] RtData;
    logic [WIDTH-1:0] Imm;
    logic             ALUSrc;
    logic [1:0]       ForwardA;
    logic [1:0]       ForwardB;
    logic [WIDTH-1:0] MemResult;
    logic [WIDTH-1:0] WbResult;
    logic             Flush;
    logic             OutValid;
    logic             OutReady;
    logic [2:0]       Ctl;
    logic [4:0]       Shamt;
    logic [WIDTH-1:0] DataA;
    logic [WIDTH-1:0] DataB;
    logic             Illegal;
    logic [CNT_W-1:0] IssueCount;

    int n_checks = 0;
    int n_errors = 0;

    alu_issue_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .InValid    (InValid),
        .InReady    (InReady),
        .ALUOp      (ALUOp),
        .Funct      (Funct),
        .ShamtIn    (ShamtIn),
        .RsData     (RsData),
        .RtData     (RtData),
        .Imm        (Imm),
        .ALUSrc     (ALUSrc),
        .ForwardA   (ForwardA),
        .ForwardB   (ForwardB),
        .MemResult  (MemResult),
        .WbResult   (WbResult),
        .Flush      (Flush),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .Ctl        (Ctl),
        .Shamt      (Shamt),
        .DataA      (DataA),
        .DataB      (DataB),
        .Illegal    (Illegal),
        .IssueCount (IssueCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] sw_funct [7];
    logic [2:0] sw_ctl   [7];
    logic       sw_ill   [7];

    initial begin
        sw_funct = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h02, 6'h3F};
        sw_ctl   = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b111, 3'b010};
        sw_ill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; InValid = 1'b1; ALUOp = 2'b10; Funct = 6'h20; ShamtIn = 5'd7;
        RsData = 32'h1234; RtData = 32'h5678; Imm = 32'h0; ALUSrc = 1'b0;
        ForwardA = 2'b00; ForwardB = 2'b00; MemResult = 32'h0; WbResult = 32'h0;
        Flush = 1'b0; OutReady = 1'b1;

        // Reset held for two cycles with a valid instruction offered
        tick(); tick();
        chk("rst_valid", {31'b0, OutValid}, 32'd0);
        chk("rst_ctl",   {29'b0, Ctl}, 32'd0);
        chk("rst_dataa", DataA, 32'd0);
        chk("rst_datab", DataB, 32'd0);
        chk("rst_shamt", {27'b0, Shamt}, 32'd0);
        chk("rst_ill",   {31'b0, Illegal}, 32'd0);
        chk("rst_cnt",   {28'b0, IssueCount}, 32'd0);
        rst = 1'b0;

        // Decode sweep, back to back: first load has no transfer, later six do
        for (int i = 0; i < 7; i++) begin
            ALUOp = 2'b10; Funct = sw_funct[i]; ShamtIn = 5'(i + 1);
            tick();
            chk($sformatf("sw_ctl%0d", i), {29'b0, Ctl}, {29'b0, sw_ctl[i]});
            chk($sformatf("sw_ill%0d", i), {31'b0, Illegal}, {31'b0, sw_ill[i]});
            chk($sformatf("sw_sh%0d", i), {27'b0, Shamt}, i + 1);
        end
        chk("sw_cnt", {28'b0, IssueCount}, 32'd6);
        InValid = 1'b0;
        tick();
        chk("drain_valid", {31'b0, OutValid}, 32'd0);
        chk("drain_cnt",   {28'b0, IssueCount}, 32'd7);
        chk("drain_ctl",   {29'b0, Ctl}, 32'b010);

        // Forwarding and immediate select
        InValid = 1'b1; ALUOp = 2'b00; RsData = 32'd5; MemResult = 32'd9; ForwardA = 2'b01;
        ALUSrc = 1'b1; Imm = 32'hFFFF_FFFC; ForwardB = 2'b10; WbResult = 32'h77; RtData = 32'd3;
        tick();
        chk("fwd_a_mem", DataA, 32'd9);
        chk("fwd_b_imm", DataB, 32'hFFFF_FFFC);
        chk("fwd_ctl",   {29'b0, Ctl}, 32'b010);
        ALUOp = 2'b01; ForwardA = 2'b10; ForwardB = 2'b11; ALUSrc = 1'b0;
        tick();
        chk("fwd_a_wb",  DataA, 32'h77);
        chk("fwd_b_rt",  DataB, 32'd3);
        chk("br_ctl",    {29'b0, Ctl}, 32'b110);
        ALUOp = 2'b11; Funct = 6'h3F; ForwardA = 2'b11; ForwardB = 2'b01;
        tick();
        chk("fwd_a_rs",  DataA, 32'd5);
        chk("fwd_b_mem", DataB, 32'd9);
        chk("ori_ctl",   {29'b0, Ctl}, 32'b001);
        chk("ori_ill",   {31'b0, Illegal}, 32'd0);
        chk("fwd_cnt",   {28'b0, IssueCount}, 32'd9);
        InValid = 1'b0;
        tick();
        chk("fwd_drain_cnt", {28'b0, IssueCount}, 32'd10);

        // Stall: load add, hold three cycles with changing inputs
        InValid = 1'b1; OutReady = 1'b0; ALUOp = 2'b00; RsData = 32'h11; RtData = 32'h22;
        ForwardA = 2'b00; ForwardB = 2'b00; ALUSrc = 1'b0; ShamtIn = 5'd3;
        tick();
        chk("st_load_valid", {31'b0, OutValid}, 32'd1);
        chk("st_load_a",     DataA, 32'h11);
        chk("st_inready",    {31'b0, InReady}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            RsData = 32'hAA; RtData = 32'hBB; ALUOp = 2'b01; ShamtIn = 5'd9;
            tick();
            chk($sformatf("st_a%0d", i),  DataA, 32'h11);
            chk($sformatf("st_b%0d", i),  DataB, 32'h22);
            chk($sformatf("st_c%0d", i),  {29'b0, Ctl}, 32'b010);
            chk($sformatf("st_sh%0d", i), {27'b0, Shamt}, 32'd3);
            chk($sformatf("st_v%0d", i),  {31'b0, OutValid}, 32'd1);
            chk($sformatf("st_r%0d", i),  {31'b0, InReady}, 32'd0);
            chk($sformatf("st_n%0d", i),  {28'b0, IssueCount}, 32'd10);
        end
        OutReady = 1'b1;
        tick();
        chk("st_rel_a",   DataA, 32'hAA);
        chk("st_rel_ctl", {29'b0, Ctl}, 32'b110);
        chk("st_rel_cnt", {28'b0, IssueCount}, 32'd11);

        // Flush during hold with a new instruction offered
        OutReady = 1'b0; RsData = 32'h55;
        tick();
        chk("fl_hold_a", DataA, 32'hAA);
        Flush = 1'b1;
        tick();
        chk("fl_valid", {31'b0, OutValid}, 32'd0);
        chk("fl_a",     DataA, 32'hAA);
        chk("fl_cnt",   {28'b0, IssueCount}, 32'd11);
        Flush = 1'b0; OutReady = 1'b1; RsData = 32'h66;
        tick();
        chk("fl_next_valid", {31'b0, OutValid}, 32'd1);
        chk("fl_next_a",     DataA, 32'h66);
        // Flush coinciding with a transfer still counts it
        Flush = 1'b1;
        tick();
        chk("fl_xfer_valid", {31'b0, OutValid}, 32'd0);
        chk("fl_xfer_cnt",   {28'b0, IssueCount}, 32'd12);
        Flush = 1'b0;

        // Reset in the middle of a hold
        OutReady = 1'b0; RsData = 32'h99;
        tick();
        chk("rh_valid", {31'b0, OutValid}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rh_rst_valid", {31'b0, OutValid}, 32'd0);
        chk("rh_rst_a",     DataA, 32'd0);
        chk("rh_rst_cnt",   {28'b0, IssueCount}, 32'd0);
        rst = 1'b0;

        // 17 back-to-back transfers wrap the 4-bit counter to 1
        OutReady = 1'b1; InValid = 1'b1; ALUOp = 2'b00;
        for (int k = 0; k < 17; k++) begin
            RsData = 32'(k + 100);
            tick();
            chk($sformatf("bb_v%0d", k), {31'b0, OutValid}, 32'd1);
            chk($sformatf("bb_a%0d", k), DataA, 32'(k + 100));
            chk($sformatf("bb_r%0d", k), {31'b0, InReady}, 32'd1);
        end
        chk("bb_cnt16", {28'b0, IssueCount}, 32'd0);
        InValid = 1'b0;
        tick();
        chk("wrap_cnt",   {28'b0, IssueCount}, 32'd1);
        chk("wrap_valid", {31'b0, OutValid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
